// File: rtl/mult_accumulator_if.sv
// Product-in / block-sum-out handshake bundle for mult_accumulator.
// slave = accumulator side, master = producer/consumer side.
interface mult_accumulator_if #(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned ACC_W  = 72
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_prod, clear, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

  modport master (
    output in_valid, in_prod, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mult_accumulator.sv
// Sums N consecutive signed products into an ACC_W-bit block result with overflow flag.
// Optional macro ACC_SATURATE_EN: each add clamps to the signed ACC_W range instead of wrapping.
module mult_accumulator #(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned ACC_W  = 72,
  parameter int unsigned N      = 16
) (
  input logic               clk,
  input logic               rst,
  mult_accumulator_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N) + 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum_raw;
  logic [ACC_W-1:0]   sum_next;
  logic               add_ovf;
  logic               beat;
  logic               last_beat;

  assign prod_ext  = ACC_W'($signed(bus.in_prod));
  assign sum_raw   = acc_q + prod_ext;
  // Signed overflow: operands agree in sign but the result does not.
  assign add_ovf   = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
  assign beat      = bus.in_valid && (state_q == ACCUM);
  assign last_beat = (cnt_q == CNT_W'(N - 1));

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  assign sum_next = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
  assign sum_next = sum_raw;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ACCUM: begin
        // clear takes priority: a beat in the same cycle is consumed and dropped
        if (bus.clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (beat) begin
          if (last_beat) begin
            out_sum_d   = sum_next;
            out_ovf_d   = ovf_q | add_ovf;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d = sum_next;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench: table vectors, hand sequences and random traffic against a
// block-sum reference model (72-bit and 64-bit accumulators driven identically, plus N=1).
module tb_mult_accumulator;

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [63:0] PMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PMIN = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv = 1'b0, clr = 1'b0, ordy = 1'b1;
  logic [63:0] prod = '0;
  logic        ivc = 1'b0;
  logic [63:0] prodc = '0;

  mult_accumulator_if #(.PROD_W(64), .ACC_W(72)) ia ();
  mult_accumulator_if #(.PROD_W(64), .ACC_W(64)) ib ();
  mult_accumulator_if #(.PROD_W(64), .ACC_W(72)) ic ();

  assign ia.in_valid = iv;   assign ib.in_valid = iv;   assign ic.in_valid = ivc;
  assign ia.in_prod  = prod; assign ib.in_prod  = prod; assign ic.in_prod  = prodc;
  assign ia.clear    = clr;  assign ib.clear    = clr;  assign ic.clear    = 1'b0;
  assign ia.out_ready = ordy; assign ib.out_ready = ordy; assign ic.out_ready = 1'b1;

  mult_accumulator #(.PROD_W(64), .ACC_W(72), .N(4)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  mult_accumulator #(.PROD_W(64), .ACC_W(64), .N(4)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  mult_accumulator #(.PROD_W(64), .ACC_W(72), .N(1)) u_c (.clk(clk), .rst(rst), .bus(ic.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    chk_v(nm, {127'b0, act}, {127'b0, exp});
  endtask

  // Reference model: products of the open block, and the pending result if any.
  logic signed [63:0]  blk[$];
  bit                  exp_valid = 1'b0;
  logic signed [127:0] exp_sa, exp_sb;
  bit                  exp_oa, exp_ob;

  task automatic model_sum(input int accw, input bit sat,
                           output logic signed [127:0] s, output bit o);
    logic signed [127:0] acc, t, mx, mn;
    mx  = (128'sd1 <<< (accw - 1)) - 128'sd1;
    mn  = -(128'sd1 <<< (accw - 1));
    acc = '0;
    o   = 1'b0;
    foreach (blk[k]) begin
      t = acc + blk[k];
      if (t > mx || t < mn) begin
        o = 1'b1;
        if (sat) t = (t > mx) ? mx : mn;
        else     t = (t <<< (128 - accw)) >>> (128 - accw);
      end
      acc = t;
    end
    s = acc;
  endtask

  task automatic model_reset();
    blk.delete();
    exp_valid = 1'b0;
  endtask

  task automatic step();
    bit was_valid, accepted;
    was_valid = exp_valid;
    accepted  = iv && !was_valid;
    if (was_valid && ordy) exp_valid = 1'b0;
    @(posedge clk);
    #1;
    if (!was_valid && clr) blk.delete();
    else if (accepted) begin
      blk.push_back(prod);
      if (blk.size() == 4) begin
        model_sum(72, SAT, exp_sa, exp_oa);
        model_sum(64, SAT, exp_sb, exp_ob);
        exp_valid = 1'b1;
        blk.delete();
      end
    end
    chk_b("in_ready_a", ia.in_ready, !exp_valid);
    chk_b("in_ready_b", ib.in_ready, !exp_valid);
    chk_b("out_valid_a", ia.out_valid, exp_valid);
    chk_b("out_valid_b", ib.out_valid, exp_valid);
    if (exp_valid) begin
      chk_v("model_sum_a", {56'b0, ia.out_sum}, {56'b0, exp_sa[71:0]});
      chk_b("model_ovf_a", ia.out_ovf, exp_oa);
      chk_v("model_sum_b", {64'b0, ib.out_sum}, {64'b0, exp_sb[63:0]});
      chk_b("model_ovf_b", ib.out_ovf, exp_ob);
    end
  endtask

  task automatic beats(input logic [63:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      iv = 1'b1; prod = v; step();
    end
    iv = 1'b0;
  endtask

  function automatic logic [63:0] rand_prod();
    logic signed [63:0] t;
    case ($urandom_range(0, 3))
      0: t = {$urandom, $urandom};
      1: t = 64'($urandom_range(0, 2000)) - 64'sd1000;
      2: t = $urandom_range(0, 1) ? PMAX : PMIN;
      default: t = PMAX - 64'($urandom_range(0, 50));
    endcase
    return t;
  endfunction

  typedef struct {
    logic [63:0] b [4];
    logic [71:0] sa;
    logic        oa;
    logic [63:0] sb;
    logic        ob;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{b: '{64'd1, 64'd2, 64'd3, 64'd4}, sa: 72'd10, oa: 1'b0, sb: 64'd10, ob: 1'b0};
    tbl[1] = '{b: '{-64'sd5, 64'd3, -64'sd7, 64'd2}, sa: 72'hFF_FFFF_FFFF_FFFF_FFF9, oa: 1'b0,
               sb: 64'hFFFF_FFFF_FFFF_FFF9, ob: 1'b0};
`ifdef ACC_SATURATE_EN
    tbl[2] = '{b: '{PMAX, PMAX, PMAX, PMAX}, sa: 72'h01_FFFF_FFFF_FFFF_FFFC, oa: 1'b0,
               sb: 64'h7FFF_FFFF_FFFF_FFFF, ob: 1'b1};
    tbl[3] = '{b: '{PMIN, PMIN, PMIN, PMIN}, sa: 72'hFE_0000_0000_0000_0000, oa: 1'b0,
               sb: 64'h8000_0000_0000_0000, ob: 1'b1};
`else
    tbl[2] = '{b: '{PMAX, PMAX, PMAX, PMAX}, sa: 72'h01_FFFF_FFFF_FFFF_FFFC, oa: 1'b0,
               sb: 64'hFFFF_FFFF_FFFF_FFFC, ob: 1'b1};
    tbl[3] = '{b: '{PMIN, PMIN, PMIN, PMIN}, sa: 72'hFE_0000_0000_0000_0000, oa: 1'b0,
               sb: 64'h0000_0000_0000_0000, ob: 1'b1};
`endif
    tbl[4] = '{b: '{64'd100, -64'sd100, 64'd7, -64'sd8}, sa: '1, oa: 1'b0, sb: '1, ob: 1'b0};

    // Reset values
    #3;
    chk_b("rst_out_valid", ia.out_valid, 1'b0);
    chk_b("rst_in_ready", ia.in_ready, 1'b1);
    chk_v("rst_out_sum", {56'b0, ia.out_sum}, '0);
    chk_b("rst_out_ovf", ia.out_ovf, 1'b0);
    chk_b("rst_out_valid_c", ic.out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step();

    // Table vectors, back-to-back with out_ready high
    ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        iv = 1'b1; prod = tbl[i].b[j];
        step();
      end
      iv = 1'b0;
      chk_b("tbl_valid", ia.out_valid, 1'b1);
      chk_v("tbl_sum_a", {56'b0, ia.out_sum}, {56'b0, tbl[i].sa});
      chk_b("tbl_ovf_a", ia.out_ovf, tbl[i].oa);
      chk_v("tbl_sum_b", {64'b0, ib.out_sum}, {64'b0, tbl[i].sb});
      chk_b("tbl_ovf_b", ib.out_ovf, tbl[i].ob);
      chk_b("tbl_in_ready_low", ia.in_ready, 1'b0);
      step();
      chk_b("tbl_valid_one_cycle", ia.out_valid, 1'b0);
      chk_b("tbl_in_ready_back", ia.in_ready, 1'b1);
    end

    // Back-pressure: result held, no beats taken, clear ignored in HOLD
    ordy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      iv = 1'b1; prod = 64'(k); step();
    end
    prod = 64'd55;
    for (int k = 0; k < 5; k++) begin
      clr = (k == 2);
      step();
      chk_b("bp_valid", ia.out_valid, 1'b1);
      chk_v("bp_sum", {56'b0, ia.out_sum}, 128'd10);
      chk_b("bp_in_ready", ia.in_ready, 1'b0);
    end
    clr = 1'b0; iv = 1'b0; ordy = 1'b1;
    step();
    chk_b("bp_released", ia.out_valid, 1'b0);
    beats(64'd2, 4);
    chk_v("bp_next_block", {56'b0, ia.out_sum}, 128'd8);
    step();

    // clear in ACCUM discards the partial sum and the concurrent beat
    beats(64'd10, 1);
    beats(64'd20, 1);
    iv = 1'b1; prod = 64'd99; clr = 1'b1; step();
    clr = 1'b0;
    beats(64'd1, 4);
    chk_b("clr_valid", ia.out_valid, 1'b1);
    chk_v("clr_sum", {56'b0, ia.out_sum}, 128'd4);
    step();

    // Asynchronous reset mid-block
    beats(64'd5, 3);
    #2 rst = 1'b1;
    #1;
    chk_b("arst_valid", ia.out_valid, 1'b0);
    chk_b("arst_in_ready", ia.in_ready, 1'b1);
    chk_v("arst_sum", {56'b0, ia.out_sum}, '0);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 4; k++) begin
      iv = 1'b1; prod = 64'(k); step();
    end
    iv = 1'b0;
    chk_v("arst_after_sum", {56'b0, ia.out_sum}, 128'd10);

    // Asynchronous reset while holding a result
    ordy = 1'b0;
    step();
    chk_b("hold_before_rst", ia.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_b("hold_rst_valid", ia.out_valid, 1'b0);
    chk_b("hold_rst_ovf", ib.out_ovf, 1'b0);
    chk_b("hold_rst_in_ready", ib.in_ready, 1'b1);
    #1 rst = 1'b0;
    model_reset();
    ordy = 1'b1;
    step();

    // N = 1: every accepted beat is final
    ivc = 1'b1; prodc = 64'd7; step();
    chk_b("n1_valid", ic.out_valid, 1'b1);
    chk_v("n1_sum", {56'b0, ic.out_sum}, 128'd7);
    chk_b("n1_in_ready", ic.in_ready, 1'b0);
    prodc = -64'sd3; step();
    chk_b("n1_gap", ic.out_valid, 1'b0);
    step();
    chk_b("n1_valid2", ic.out_valid, 1'b1);
    chk_v("n1_sum2", {56'b0, ic.out_sum}, {56'b0, 72'hFF_FFFF_FFFF_FFFF_FFFD});
    ivc = 1'b0;
    step();

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = $urandom_range(0, 1);
      clr  = ($urandom_range(0, 19) == 0);
      prod = rand_prod();
      step();
    end
    iv = 1'b0; clr = 1'b0; ordy = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
